fir_mac_sched: RTL and testbench

- Time-multiplexed controller that shares one multiply-accumulate datapath across all taps of an ANC FIR filter (e.g. the secondary-path or control filter).
- Per accepted input sample it:
  - shifts the sample into an internal delay line;
  - steps a coefficient-RAM read port over all taps, accumulating products into a wide accumulator;
  - scales, saturates and presents one filtered output sample through a valid/ready handshake.
- Sits between the ADC decimator output and the anti-noise DAC path.

---
 rtl/anc_pkg.sv | 30 +++
 rtl/fir_mac_sched_sat.sv | 32 +++
 rtl/fir_mac_sched.sv | 159 +++++++++++++++
 tb/tb_fir_mac_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/anc_pkg.sv
`default_nettype none
// ============================================================================
// Module : anc_pkg
// Brief  : Shared types, default widths and helpers for the ANC FIR datapath.
// Rev    : 1.0  initial release
// ============================================================================
package anc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int c_DATA_W = 16;
  localparam int c_COEF_W = 16;
  localparam int c_ACC_W  = 40;
  localparam int c_FRAC   = 15;
  localparam int c_OUT_W  = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_sched_sat.sv
`default_nettype none
// ============================================================================
// Module : fir_mac_sched_sat
// Brief  : Signed saturation of an IN_W-bit value down to OUT_W bits.
// Rev    : 1.0  initial release
// ============================================================================
module fir_mac_sched_sat #(
  parameter int IN_W  = 25,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o
);

  logic [IN_W-OUT_W:0] w_hi;
  logic                w_fits;

  // The value fits iff every bit from the output sign bit upward agrees.
  always_comb begin
    w_hi   = din_i[IN_W-1:OUT_W-1];
    w_fits = (&w_hi) | ~(|w_hi);
    if (w_fits) begin
      dout_o = din_i[OUT_W-1:0];
    end else if (din_i[IN_W-1]) begin
      dout_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      dout_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_mac_sched.sv
`default_nettype none
// ============================================================================
// Module : fir_mac_sched
// Brief  : Time-multiplexed single-MAC FIR scheduler with saturated output.
//          Define FIR_MAC_SCHED_ROUND_EN for round-half-up before the shift.
// Rev    : 1.0  initial release
// ============================================================================
module fir_mac_sched
  import anc_pkg::*;
#(
  parameter int TAPS   = 16,
  parameter int DATA_W = c_DATA_W,
  parameter int COEF_W = c_COEF_W,
  parameter int ACC_W  = c_ACC_W,
  parameter int FRAC   = c_FRAC,
  parameter int OUT_W  = c_OUT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic [clog2(TAPS)-1:0]    coef_addr,
  output logic                      coef_rd,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      sat_flag
);

  localparam int AW        = clog2(TAPS);
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int MIN_ACC_W = PROD_W + clog2(TAPS);
`ifdef FIR_MAC_SCHED_ROUND_EN
  localparam int SUM_W = ACC_W + 1;
  localparam logic [SUM_W-1:0] c_HALF = SUM_W'(64'd1 << (FRAC - 1));
`else
  localparam int SUM_W = ACC_W;
`endif
  localparam int RES_W = SUM_W - FRAC;
  localparam logic [AW-1:0] c_LAST = AW'(TAPS - 1);

  if (ACC_W < MIN_ACC_W) begin : g_acc_w_check
    $error("fir_mac_sched: ACC_W=%0d below minimum %0d", ACC_W, MIN_ACC_W);
  end

  state_t                    state_q;
  logic signed [DATA_W-1:0]  x_q [TAPS];
  logic signed [DATA_W-1:0]  xk_q;
  logic signed [DATA_W-1:0]  xd_q;
  logic                      mvalid_q;
  logic                      coef_rd_q;
  logic [AW-1:0]             addr_q;
  logic [AW-1:0]             addr_d;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic                      out_valid_q;
  logic signed [OUT_W-1:0]   out_q;
  logic                      sat_q;

  logic signed [PROD_W-1:0]  w_prod;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [RES_W-1:0]   w_res;
  logic signed [OUT_W-1:0]   w_sat;
  logic                      w_clip;

  // xd_q/coef_data line up one cycle after the read strobe; acc_d is also the
  // final sum used in DRAIN, so the last product never needs an extra cycle.
  always_comb begin
    addr_d = addr_q + 1'b1;
    w_prod = xd_q * coef_data;
    acc_d  = acc_q + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
`ifdef FIR_MAC_SCHED_ROUND_EN
    w_sum  = {acc_d[ACC_W-1], acc_d} + c_HALF;
`else
    w_sum  = acc_d;
`endif
    w_res  = RES_W'(w_sum >>> FRAC);
    w_clip = (w_res != {{(RES_W-OUT_W){w_sat[OUT_W-1]}}, w_sat});
  end

  fir_mac_sched_sat #(
    .IN_W  (RES_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .din_i  (w_res),
    .dout_o (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
      xk_q        <= '0;
      xd_q        <= '0;
      mvalid_q    <= 1'b0;
      coef_rd_q   <= 1'b0;
      addr_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      mvalid_q <= coef_rd_q;
      xd_q     <= xk_q;
      if (mvalid_q) acc_q <= acc_d;

      case (state_q)
        IDLE: begin
          if (flush) begin
            for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
          end else if (in_valid && in_ready) begin
            for (int i = TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
            x_q[0]    <= in_data;
            xk_q      <= in_data;
            acc_q     <= '0;
            coef_rd_q <= 1'b1;
            addr_q    <= '0;
            state_q   <= MAC;
          end
        end
        MAC: begin
          if (addr_q == c_LAST) begin
            coef_rd_q <= 1'b0;
            addr_q    <= '0;
            state_q   <= DRAIN;
          end else begin
            addr_q <= addr_d;
            xk_q   <= x_q[addr_d];
          end
        end
        DRAIN: begin
          out_q       <= w_sat;
          sat_q       <= w_clip;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !flush && !rst;
  assign coef_addr = addr_q;
  assign coef_rd   = coef_rd_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign sat_flag  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_fir_mac_sched
// Brief  : Self-checking bench for fir_mac_sched (TAPS=4, FRAC=15).
// Rev    : 1.0  initial release
// ============================================================================
module tb_fir_mac_sched;

  localparam int TAPS = 4;
`ifdef FIR_MAC_SCHED_ROUND_EN
  localparam int c_RND = 1;
`else
  localparam int c_RND = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, coef_rd, out_valid, sat_flag;
  logic signed [15:0] in_data = '0;
  logic signed [15:0] coef_data = '0;
  logic signed [15:0] out_data;
  logic [1:0] coef_addr;
  logic signed [15:0] coef_mem [TAPS];

  fir_mac_sched #(
    .TAPS(TAPS), .DATA_W(16), .COEF_W(16), .ACC_W(40), .FRAC(15), .OUT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_addr(coef_addr), .coef_rd(coef_rd), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // One-cycle-latency coefficient RAM
  always @(posedge clk) if (coef_rd) coef_data <= coef_mem[coef_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int y; int s; } exp_t;
  exp_t exp_q[$];

  typedef struct { int grp; int x; int y; int s; } vec_t;
  vec_t vecs[14];
  int coefs [4][TAPS];

  int  acc_cyc = 0;
  int  hs_cyc  = 0;
  int  rises   = 0;
  logic ov_q = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ov_q = 1'b0;
    end else begin
      if (out_valid && !ov_q) begin
        rises++;
        chk("latency", cyc - acc_cyc, TAPS + 2);
      end
      ov_q = out_valid;
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), e.y);
          chk("sat_flag", int'(sat_flag), e.s);
        end
      end
    end
  end

  task automatic send(input int x, input int y, input int s);
    int  n;
    bit  ok;
    exp_t e;
    n  = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'(x);
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        ok      = 1'b1;
        acc_cyc = cyc;
        e.y = y;
        e.s = s;
        exp_q.push_back(e);
      end
      n++;
      if (!ok) @(posedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept_timeout", int'(ok), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Flush is always issued together with a competing sample that must lose.
  task automatic do_flush();
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'sd12345;
    @(negedge clk);
    chk("flush_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic load_coefs(input int g);
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 16'(coefs[g][k]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int n;
    int r0;
    exp_t e;

    coefs[0] = '{16384, -8192, 4096, 0};
    coefs[1] = '{32767, 32767, 32767, 32767};
    coefs[2] = '{32767, 32767, 32767, 32767};
    coefs[3] = '{16384, 0, 0, 0};
    vecs[0]  = '{0, 16384,  8192, 0};
    vecs[1]  = '{0, 0,     -4096, 0};
    vecs[2]  = '{0, 0,      2048, 0};
    vecs[3]  = '{0, 0,         0, 0};
    vecs[4]  = '{1, 32767,  32766, 0};
    vecs[5]  = '{1, 32767,  32767, 1};
    vecs[6]  = '{1, 32767,  32767, 1};
    vecs[7]  = '{1, 32767,  32767, 1};
    vecs[8]  = '{2, -32768, -32767, 0};
    vecs[9]  = '{2, -32768, -32768, 1};
    vecs[10] = '{2, -32768, -32768, 1};
    vecs[11] = '{2, -32768, -32768, 1};
    vecs[12] = '{3, 1,  (c_RND != 0) ? 1 : 0,  0};
    vecs[13] = '{3, -1, (c_RND != 0) ? 0 : -1, 0};
    load_coefs(0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_coef_rd", int'(coef_rd), 0);
    chk("rst_coef_addr", int'(coef_addr), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Table-driven vectors
    cur = -1;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].grp != cur) begin
        cur = vecs[i].grp;
        load_coefs(cur);
        do_flush();
      end
      send(vecs[i].x, vecs[i].y, vecs[i].s);
      drain();
    end

    // Backpressure with the next sample already waiting
    load_coefs(0);
    do_flush();
    out_ready = 1'b0;
    send(16384, 8192, 0);
    in_valid = 1'b1;
    in_data  = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 30);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_data", int'(out_data), 8192);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 10);
    chk("bp_accept_cycle", cyc - hs_cyc, 1);
    acc_cyc = cyc;
    e.y = -4096;
    e.s = 0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Flush beats a simultaneous sample and clears the history
    do_flush();
    for (int k = 0; k < 3; k++) begin
      send(0, 0, 0);
      drain();
    end

    // Reset during MAC cycle 2 discards the result and the history
    send(16384, 8192, 0);
    drain();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'sd5000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    r0  = rises;
    @(negedge clk);
    chk("abort_rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    repeat (12) @(negedge clk);
    chk("abort_no_output", rises - r0, 0);
    send(0, 0, 0);
    drain();
    send(16384, 8192, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
